// File: rtl/pc_csr_reg_pkg.sv
// Shared definitions for the pc_csr_reg front-end block.
// Covers the bus width, the read/write encodings and the machine-mode CSR addresses.
package pc_csr_reg_pkg;

    localparam int RegBusWidth = 32;
    typedef logic [RegBusWidth-1:0] reg_bus_t;

    localparam reg_bus_t ZeroWord = '0;

    localparam logic Read  = 1'b0;
    localparam logic Write = 1'b1;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

endpackage

// File: rtl/pc_csr_reg_csr_file.sv
// Machine-mode CSR file: combinational read decode, one write port and the 64-bit mcycle counter.
module csr_file
    import pc_csr_reg_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [11:0]      csr_addr_i,
    input  reg_bus_t         csr_wdata_i,
    output reg_bus_t         csr_rdata_o
);

    reg_bus_t    r_mstatus;
    reg_bus_t    r_mie;
    reg_bus_t    r_mtvec;
    reg_bus_t    r_mscratch;
    reg_bus_t    r_mepc;
    reg_bus_t    r_mcause;
    reg_bus_t    r_mtval;
    reg_bus_t    r_mip;
    logic [63:0] r_mcycle;

    logic        w_write;
    assign w_write = (we_i == Write);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus  <= ZeroWord;
            r_mie      <= ZeroWord;
            r_mtvec    <= ZeroWord;
            r_mscratch <= ZeroWord;
            r_mepc     <= ZeroWord;
            r_mcause   <= ZeroWord;
            r_mtval    <= ZeroWord;
            r_mip      <= ZeroWord;
        end else if (w_write) begin
            case (csr_addr_i)
                CSR_MSTATUS:  r_mstatus  <= csr_wdata_i;
                CSR_MIE:      r_mie      <= csr_wdata_i;
                CSR_MTVEC:    r_mtvec    <= csr_wdata_i;
                CSR_MSCRATCH: r_mscratch <= csr_wdata_i;
                CSR_MEPC:     r_mepc     <= csr_wdata_i;
                CSR_MCAUSE:   r_mcause   <= csr_wdata_i;
                CSR_MTVAL:    r_mtval    <= csr_wdata_i;
                CSR_MIP:      r_mip      <= csr_wdata_i;
                default: ;
            endcase
        end
    end

    // A write to either half suppresses that cycle's increment for the whole counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle <= 64'd0;
        end else if (w_write && csr_addr_i == CSR_MCYCLE) begin
            r_mcycle[31:0] <= csr_wdata_i;
        end else if (w_write && csr_addr_i == CSR_MCYCLEH) begin
            r_mcycle[63:32] <= csr_wdata_i;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    always_comb begin
        csr_rdata_o = ZeroWord;
        case (csr_addr_i)
            CSR_MSTATUS:  csr_rdata_o = r_mstatus;
            CSR_MISA:     csr_rdata_o = MISA_VALUE;
            CSR_MIE:      csr_rdata_o = r_mie;
            CSR_MTVEC:    csr_rdata_o = r_mtvec;
            CSR_MSCRATCH: csr_rdata_o = r_mscratch;
            CSR_MEPC:     csr_rdata_o = r_mepc;
            CSR_MCAUSE:   csr_rdata_o = r_mcause;
            CSR_MTVAL:    csr_rdata_o = r_mtval;
            CSR_MIP:      csr_rdata_o = r_mip;
            CSR_MCYCLE:   csr_rdata_o = r_mcycle[31:0];
            CSR_MCYCLEH:  csr_rdata_o = r_mcycle[63:32];
            default:      csr_rdata_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/pc_csr_reg.sv
// Front-end state of the RV32 core: the program counter plus the machine-mode CSR file.
// Jump outranks hold; otherwise the PC advances by 4 and wraps modulo 2^32.
module pc_csr_reg
    import pc_csr_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] pc_o,
    input  logic        we_i,
    input  logic [31:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o
);

    reg_bus_t r_pc;

    // Only the 12-bit CSR index is decoded; the upper address bits are don't-care.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^csr_addr_i[31:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (jump_flag_i) begin
            r_pc <= jump_addr_i;
        end else if (!hold_flag_i) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign pc_o = r_pc;

    csr_file #(
        .MISA_VALUE (MISA_VALUE)
    ) u_csr_file (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (we_i),
        .csr_addr_i  (csr_addr_i[11:0]),
        .csr_wdata_i (csr_wdata_i),
        .csr_rdata_o (csr_rdata_o)
    );

endmodule

// File: tb/tb_pc_csr_reg.sv
// Self-checking bench for pc_csr_reg: a reference model predicts PC and CSR values,
// expected PCs are queued at drive time and popped once the clock edge has happened.
module tb_pc_csr_reg;

    logic        clk;
    logic        rst_n;
    logic        hold_flag_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [31:0] pc_o;
    logic        we_i;
    logic [31:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] pcQueue[$];

    logic [31:0] modelPc;
    logic [31:0] mStatus, mIe, mTvec, mScratch, mEpc, mCause, mTval, mIp;
    logic [63:0] mCycle;

    pc_csr_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold_flag_i (hold_flag_i),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .pc_o        (pc_o),
        .we_i        (we_i),
        .csr_addr_i  (csr_addr_i),
        .csr_wdata_i (csr_wdata_i),
        .csr_rdata_o (csr_rdata_o)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        modelPc  = 32'h0000_0000;
        mStatus  = '0; mIe = '0; mTvec = '0; mScratch = '0;
        mEpc     = '0; mCause = '0; mTval = '0; mIp = '0;
        mCycle   = '0;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [11:0] idx;
        idx = a[11:0];
        case (idx)
            12'h300: return mStatus;
            12'h301: return 32'h4000_0100;
            12'h304: return mIe;
            12'h305: return mTvec;
            12'h340: return mScratch;
            12'h341: return mEpc;
            12'h342: return mCause;
            12'h343: return mTval;
            12'h344: return mIp;
            12'hB00: return mCycle[31:0];
            12'hB80: return mCycle[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelWriteEdge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [11:0] idx;
        idx = a[11:0];
        if (we && idx == 12'hB00)      mCycle[31:0]  = d;
        else if (we && idx == 12'hB80) mCycle[63:32] = d;
        else                           mCycle        = mCycle + 64'd1;
        if (we) begin
            case (idx)
                12'h300: mStatus  = d;
                12'h304: mIe      = d;
                12'h305: mTvec    = d;
                12'h340: mScratch = d;
                12'h341: mEpc     = d;
                12'h342: mCause   = d;
                12'h343: mTval    = d;
                12'h344: mIp      = d;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive at the falling edge, check the combinational read, then the registered PC.
    task automatic applyStimulus(input string tag, input logic hold, input logic jump,
                                 input logic [31:0] jaddr, input logic we,
                                 input logic [31:0] caddr, input logic [31:0] wdata);
        logic [31:0] expPc;
        hold_flag_i = hold;
        jump_flag_i = jump;
        jump_addr_i = jaddr;
        we_i        = we;
        csr_addr_i  = caddr;
        csr_wdata_i = wdata;
        #1;
        checkOutput({tag, " rdata"}, csr_rdata_o, modelRead(caddr));
        if (jump)      expPc = jaddr;
        else if (hold) expPc = modelPc;
        else           expPc = modelPc + 32'd4;
        pcQueue.push_back(expPc);
        @(posedge clk);
        modelWriteEdge(we, caddr, wdata);
        #1;
        if (pcQueue.size() == 0) begin
            checkOutput({tag, " pc-queue-empty"}, 32'd1, 32'd0);
        end else begin
            modelPc = pcQueue.pop_front();
            checkOutput({tag, " pc"}, pc_o, modelPc);
        end
        @(negedge clk);
    endtask

    task automatic freeRun(input string tag, input logic [31:0] caddr);
        applyStimulus(tag, 1'b0, 1'b0, 32'h0, 1'b0, caddr, 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        hold_flag_i = 1'b0;
        jump_flag_i = 1'b0;
        jump_addr_i = '0;
        we_i        = 1'b0;
        csr_addr_i  = 32'h0000_0B00;
        csr_wdata_i = '0;
        modelReset();

        #50;
        checkOutput("reset pc", pc_o, 32'h0);
        checkOutput("reset mcycle", csr_rdata_o, 32'h0);
        csr_addr_i = 32'h0000_0300;
        #1;
        checkOutput("reset mstatus", csr_rdata_o, 32'h0);
        #49;
        rst_n = 1'b1;

        // Free run up to pc 0x20 while reading mcycle and mcycleh
        for (int i = 0; i < 8; i++) begin
            freeRun("run", (i % 2 == 0) ? 32'h0000_0B00 : 32'h0000_0B80);
        end
        checkOutput("pc at 0x20", pc_o, 32'h20);

        for (int i = 0; i < 5; i++) begin
            applyStimulus("hold", 1'b1, 1'b0, 32'h0, 1'b0, 32'h301, 32'h0);
        end
        freeRun("release", 32'h301);

        applyStimulus("jump1", 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
        applyStimulus("jump2", 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
        freeRun("after jump", 32'h0);
        applyStimulus("jump+hold", 1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0, 32'h0);
        applyStimulus("unaligned jump", 1'b0, 1'b1, 32'h0000_1003, 1'b0, 32'h0, 32'h0);
        freeRun("unaligned run", 32'h0);
        applyStimulus("jump top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        freeRun("pc wrap", 32'h0);
        freeRun("pc after wrap", 32'h0);

        applyStimulus("misa write", 1'b0, 1'b0, 32'h0, 1'b1, 32'h301, 32'hDEAD_BEEF);
        freeRun("misa read", 32'h301);
        applyStimulus("mstatus write", 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 32'hA5A5_0F0F);
        freeRun("mstatus read", 32'h300);
        applyStimulus("mscratch hi-addr write", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_F340, 32'h1357_9BDF);
        freeRun("mscratch read", 32'h340);
        applyStimulus("mtval write", 1'b0, 1'b0, 32'h0, 1'b1, 32'h343, 32'h0BAD_F00D);
        freeRun("mtval read", 32'h343);
        freeRun("mstatus kept", 32'h300);

        applyStimulus("mcycle write", 1'b0, 1'b0, 32'h0, 1'b1, 32'hB00, 32'hFFFF_FFFF);
        freeRun("mcycleh before wrap", 32'hB80);
        freeRun("mcycle wrapped", 32'hB00);
        freeRun("mcycleh carried", 32'hB80);
        applyStimulus("mcycleh write", 1'b0, 1'b0, 32'h0, 1'b1, 32'hB80, 32'h0000_00AA);
        freeRun("mcycle after hi write", 32'hB00);
        freeRun("mcycleh read", 32'hB80);

        applyStimulus("unimpl write", 1'b0, 1'b0, 32'h0, 1'b1, 32'h7C0, 32'hFFFF_FFFF);
        freeRun("unimpl read", 32'h7C0);

        // Asynchronous reset in the middle of a pending jump and write
        hold_flag_i = 1'b0;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_8000;
        we_i        = 1'b1;
        csr_addr_i  = 32'h300;
        csr_wdata_i = 32'h1111_2222;
        #5;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset pc", pc_o, 32'h0);
        checkOutput("async reset mstatus", csr_rdata_o, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset held pc", pc_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        freeRun("post reset mstatus", 32'h300);
        freeRun("post reset mcycle", 32'hB00);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: bench did not finish within budget");
        $fatal(1, "[TB] timeout");
    end

endmodule
